arbitrated_fifo_top: RTL

ARBITRATED_FIFO_TOP -- requirements
Module: arbitrated_fifo_top

---
 rtl/arbitrated_fifo_top.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/arbitrated_fifo_top.sv
// arbitrated_fifo_top: NCH independent FIFOs drained round-robin into one
// registered output stage, plus a single-shot ordering scoreboard.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   push         per-channel write request (dropped while full)
//   data_in      per-channel write data, channel c at [c*WIDTH +: WIDTH]
//   out_rdy      downstream accepts data_out
//   start        arm the scoreboard on the word pushed to start_ch
//   start_ch     channel tracked by the scoreboard
//   empty/full   per-channel occupancy flags (registered state only)
//   data_out     registered output word
//   data_out_vld data_out holds a valid word
//   data_out_ch  source channel of data_out
//   prop_signal  1 unless the tracked word reaches the output wrong
`ifndef FIFO_DWIDTH
`define FIFO_DWIDTH 8
`endif
`ifndef FIFO_DEPTH
`define FIFO_DEPTH 4
`endif
`ifndef ARB_QWID
`define ARB_QWID 3
`endif

module arbitrated_fifo_top #(
   parameter int WIDTH = `FIFO_DWIDTH,
   parameter int DEPTH = `FIFO_DEPTH,
   parameter int NCH   = 4,
   parameter int QWID  = `ARB_QWID
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NCH-1:0]           push,
   input  logic [NCH*WIDTH-1:0]     data_in,
   input  logic                     out_rdy,
   input  logic                     start,
   input  logic [$clog2(NCH)-1:0]   start_ch,
   output logic [NCH-1:0]           empty,
   output logic [NCH-1:0]           full,
   output logic [WIDTH-1:0]         data_out,
   output logic                     data_out_vld,
   output logic [$clog2(NCH)-1:0]   data_out_ch,
   output logic                     prop_signal
);

   localparam int CW = $clog2(NCH);
   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;

   typedef enum logic [1:0] {
      IDLE,
      TRACK,
      CHECK,
      DONE
   } sb_state_e;

   logic [WIDTH-1:0] mem_q  [NCH][DEPTH];
   logic [AW-1:0]    wptr_q [NCH];
   logic [AW-1:0]    rptr_q [NCH];
   logic [OW-1:0]    cnt_q  [NCH];

   logic [WIDTH-1:0] dout_q;
   logic [CW-1:0]    dch_q;
   logic             dvld_q;
   logic [CW-1:0]    last_q;

   sb_state_e        st_q, st_d;
   logic [QWID-1:0]  cd_q, cd_d;
   logic [WIDTH-1:0] sb_word_q, sb_word_d;
   logic [CW-1:0]    sb_ch_q, sb_ch_d;

   logic [NCH-1:0]   push_acc;
   logic [NCH-1:0]   pop_v;
   logic             load_en;
   logic             gnt_found;
   logic [CW-1:0]    gnt_ch;
   logic [WIDTH-1:0] head;

   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         empty[c] = (cnt_q[c] == '0);
         full[c]  = (cnt_q[c] == OW'(DEPTH));
      end
   end

   assign push_acc = push & ~full;
   assign load_en  = !dvld_q || out_rdy;

   // Round-robin: first non-empty channel after the last grant.
   always_comb begin
      int j;
      j         = 0;
      gnt_found = 1'b0;
      gnt_ch    = '0;
      for (int i = 1; i <= NCH; i++) begin
         j = int'(last_q) + i;
         if (j >= NCH) j = j - NCH;
         if (!gnt_found && !empty[CW'(j)]) begin
            gnt_found = 1'b1;
            gnt_ch    = CW'(j);
         end
      end
   end

   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         pop_v[c] = load_en && gnt_found && (gnt_ch == CW'(c));
      end
   end

   assign head = mem_q[gnt_ch][rptr_q[gnt_ch]];

   // Storage is not reset; cleared pointers make old words unreachable.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (push_acc[c]) begin
            mem_q[c][wptr_q[c]] <= data_in[c*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < NCH; c++) begin
            wptr_q[c] <= '0;
            rptr_q[c] <= '0;
            cnt_q[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (push_acc[c]) wptr_q[c] <= wptr_q[c] + 1'b1;
            if (pop_v[c])    rptr_q[c] <= rptr_q[c] + 1'b1;
            case ({push_acc[c], pop_v[c]})
               2'b10:   cnt_q[c] <= cnt_q[c] + 1'b1;
               2'b01:   cnt_q[c] <= cnt_q[c] - 1'b1;
               default: cnt_q[c] <= cnt_q[c];
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout_q <= '0;
         dch_q  <= '0;
         dvld_q <= 1'b0;
         last_q <= CW'(NCH - 1);
      end else if (load_en) begin
         if (gnt_found) begin
            dout_q <= head;
            dch_q  <= gnt_ch;
            dvld_q <= 1'b1;
            last_q <= gnt_ch;
         end else begin
            dvld_q <= 1'b0;
         end
      end
   end

   assign data_out     = dout_q;
   assign data_out_ch  = dch_q;
   assign data_out_vld = dvld_q;

   // Countdown = words ahead of the tracked one in its FIFO.
   always_comb begin
      st_d      = st_q;
      cd_d      = cd_q;
      sb_word_d = sb_word_q;
      sb_ch_d   = sb_ch_q;
      unique case (st_q)
         IDLE: begin
            if (start && push_acc[start_ch]) begin
               st_d      = TRACK;
               sb_word_d = data_in[start_ch*WIDTH +: WIDTH];
               sb_ch_d   = start_ch;
               cd_d      = QWID'(cnt_q[start_ch])
                         - QWID'(pop_v[start_ch]);
            end
         end
         TRACK: begin
            if (pop_v[sb_ch_q]) begin
               if (cd_q == '0) st_d = CHECK;
               else            cd_d = cd_q - 1'b1;
            end
         end
         CHECK: st_d = DONE;
         DONE:  st_d = DONE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q      <= IDLE;
         cd_q      <= '0;
         sb_word_q <= '0;
         sb_ch_q   <= '0;
      end else begin
         st_q      <= st_d;
         cd_q      <= cd_d;
         sb_word_q <= sb_word_d;
         sb_ch_q   <= sb_ch_d;
      end
   end

   assign prop_signal = !((st_q == CHECK) &&
                          (!dvld_q ||
                           (dout_q != sb_word_q) ||
                           (dch_q != sb_ch_q)));

endmodule
